// File: rtl/wb_port_if.sv
// Bundle of signals between the in-order pipeline, the two long-latency
// units (0 = fdiv, 1 = fsqrt), decode, and the shared register-file write port.
// Handshake: a long-unit result transfers on a rising edge where
// lu_valid[i] & lu_ready[i]. lu_ready[i] is high only in the cycle unit i is
// granted. lu_rd/lu_fpu/lu_result stay stable until the transfer. The pipeline
// has no ready signal: it is granted whenever pipe_wr_valid=1 and pipe_hold=0.
interface wb_port_if;
  logic             pipe_wr_valid;
  logic             pipe_fpu;
  logic [4:0]       pipe_rd;
  logic [31:0]      pipe_result;
  logic [1:0]       lu_valid;
  logic [1:0]       lu_ready;
  logic [1:0][4:0]  lu_rd;
  logic [1:0]       lu_fpu;
  logic [1:0][31:0] lu_result;
  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic             issue_fpu;
  logic [4:0]       dec_rs1;
  logic [4:0]       dec_rs2;
  logic [4:0]       dec_rs3;
  logic [4:0]       dec_rd;
  logic [3:0]       dec_use;
  logic [3:0]       dec_fpu;
  logic             stall_d;
  logic             pipe_hold;
  logic [4:0]       rd_w;
  logic [31:0]      result_w;
  logic             reg_write_w;
  logic             fpu_reg_write_w;

  modport master (
    output pipe_wr_valid, pipe_fpu, pipe_rd, pipe_result,
    output lu_valid, lu_rd, lu_fpu, lu_result,
    output issue_valid, issue_rd, issue_fpu,
    output dec_rs1, dec_rs2, dec_rs3, dec_rd, dec_use, dec_fpu,
    input  lu_ready, stall_d, pipe_hold,
    input  rd_w, result_w, reg_write_w, fpu_reg_write_w
  );

  modport slave (
    input  pipe_wr_valid, pipe_fpu, pipe_rd, pipe_result,
    input  lu_valid, lu_rd, lu_fpu, lu_result,
    input  issue_valid, issue_rd, issue_fpu,
    input  dec_rs1, dec_rs2, dec_rs3, dec_rd, dec_use, dec_fpu,
    output lu_ready, stall_d, pipe_hold,
    output rd_w, result_w, reg_write_w, fpu_reg_write_w
  );
endinterface

// File: rtl/wb_port_scheduler.sv
// Writeback port scheduler: arbitrates the single register-file write port
// between the in-order pipeline and two long-latency units. It also tracks
// registers pending from long ops so decode can stall on them, and forces a
// one-cycle pipeline hold when a long unit has been starved too long.
module wb_port_scheduler #(
  parameter int STARVE_LIMIT = 4
) (
  input logic      clk,
  input logic      rst,
  wb_port_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [63:0]     pending_q, pending_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic            rr_ptr_q;
  logic            pipe_hold_q;
  logic [4:0]      rd_q;
  logic [31:0]     result_q;
  logic            reg_write_q, fpu_reg_write_q;

  logic            grant_pipe, grant_lu, lu_sel;
  logic [1:0]      lu_ready_c;
  logic [4:0]      w_rd;
  logic [31:0]     w_result;
  logic            w_fpu;
  logic            stall_c;
  logic [3:0][4:0] dec_idx;

  assign dec_idx = {bus.dec_rd, bus.dec_rs3, bus.dec_rs2, bus.dec_rs1};

  // Grant selection: pipeline first unless held, then round-robin over long units.
  // Reset blocks every grant so an in-flight transfer is dropped immediately.
  always_comb begin
    grant_pipe = bus.pipe_wr_valid & ~pipe_hold_q & ~rst;
    grant_lu   = 1'b0;
    lu_sel     = 1'b0;
    if (!grant_pipe && !rst && (bus.lu_valid != 2'b00)) begin
      grant_lu = 1'b1;
      if (bus.lu_valid == 2'b11) lu_sel = rr_ptr_q;
      else                       lu_sel = bus.lu_valid[1];
    end
    lu_ready_c = 2'b00;
    if (grant_lu) lu_ready_c[lu_sel] = 1'b1;
    w_rd     = bus.pipe_rd;
    w_result = bus.pipe_result;
    w_fpu    = bus.pipe_fpu;
    if (grant_lu) begin
      w_rd     = bus.lu_rd[lu_sel];
      w_result = bus.lu_result[lu_sel];
      w_fpu    = bus.lu_fpu[lu_sel];
    end
  end

  // Next pending scoreboard and starvation count; an issue set wins over a same-bit clear.
  always_comb begin
    pending_d = pending_q;
    if (grant_lu) pending_d[{w_fpu, w_rd}] = 1'b0;
    if (bus.issue_valid && (bus.issue_fpu || bus.issue_rd != 5'd0))
      pending_d[{bus.issue_fpu, bus.issue_rd}] = 1'b1;
    if (grant_lu || bus.lu_valid == 2'b00) starve_d = '0;
    else if (starve_q < LIMIT)             starve_d = starve_q + 1'b1;
    else                                   starve_d = starve_q;
  end

  // Decode hazard: any used operand whose register is still pending; integer x0 is exempt.
  always_comb begin
    stall_c = 1'b0;
    for (int f = 0; f < 4; f++) begin
      if (bus.dec_use[f] && (bus.dec_fpu[f] || dec_idx[f] != 5'd0) &&
          pending_q[{bus.dec_fpu[f], dec_idx[f]}])
        stall_c = 1'b1;
    end
  end

  // State registers and the registered write port; rd/result hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q       <= '0;
      starve_q        <= '0;
      rr_ptr_q        <= 1'b0;
      pipe_hold_q     <= 1'b0;
      rd_q            <= '0;
      result_q        <= '0;
      reg_write_q     <= 1'b0;
      fpu_reg_write_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      starve_q    <= starve_d;
      pipe_hold_q <= (starve_d == LIMIT);
      if (grant_lu) rr_ptr_q <= ~lu_sel;
      if (grant_pipe || grant_lu) begin
        rd_q            <= w_rd;
        result_q        <= w_result;
        reg_write_q     <= ~w_fpu && (w_rd != 5'd0);
        fpu_reg_write_q <= w_fpu;
      end else begin
        reg_write_q     <= 1'b0;
        fpu_reg_write_q <= 1'b0;
      end
    end
  end

  assign bus.lu_ready        = lu_ready_c;
  assign bus.stall_d         = stall_c;
  assign bus.pipe_hold       = pipe_hold_q;
  assign bus.rd_w            = rd_q;
  assign bus.result_w        = result_q;
  assign bus.reg_write_w     = reg_write_q;
  assign bus.fpu_reg_write_w = fpu_reg_write_q;
endmodule

// File: tb/tb_wb_port_scheduler.sv
// Testbench for wb_port_scheduler: directed writeback, hazard, arbitration,
// starvation and reset scenarios with a queue-based write-port scoreboard.
module tb_wb_port_scheduler;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [38:0] exp_q[$];  // {rd, result, reg_write, fpu_reg_write}

  // Clock generation
  always #5 clk = ~clk;

  wb_port_if bus();

  wb_port_scheduler #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pipe_wr_valid = 1'b0; bus.pipe_fpu = 1'b0; bus.pipe_rd = '0; bus.pipe_result = '0;
    bus.lu_valid = '0; bus.lu_rd = '0; bus.lu_fpu = '0; bus.lu_result = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.issue_fpu = 1'b0;
    bus.dec_rs1 = '0; bus.dec_rs2 = '0; bus.dec_rs3 = '0; bus.dec_rd = '0;
    bus.dec_use = '0; bus.dec_fpu = '0;
  endtask

  task automatic expect_write(input logic [4:0] rd, input logic [31:0] res, input logic fpu);
    exp_q.push_back({rd, res, ~fpu && (rd != 5'd0), fpu});
  endtask

  task automatic pipe_req(input logic [4:0] rd, input logic [31:0] res, input logic fpu);
    bus.pipe_wr_valid = 1'b1; bus.pipe_rd = rd; bus.pipe_result = res; bus.pipe_fpu = fpu;
  endtask

  task automatic lu_req(input int u, input logic [4:0] rd, input logic [31:0] res, input logic fpu);
    bus.lu_valid[u] = 1'b1; bus.lu_rd[u] = rd; bus.lu_result[u] = res; bus.lu_fpu[u] = fpu;
  endtask

  task automatic issue(input logic [4:0] rd, input logic fpu);
    bus.issue_valid = 1'b1; bus.issue_rd = rd; bus.issue_fpu = fpu;
  endtask

  // Monitor: every enabled write must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && (bus.reg_write_w || bus.fpu_reg_write_w)) begin
      logic [38:0] act;
      act = {bus.rd_w, bus.result_w, bus.reg_write_w, bus.fpu_reg_write_w};
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got %0h expected none", act);
      end else begin
        check("write_port", act, exp_q.pop_front());
      end
    end
  end

  // Directed stimulus
  initial begin
    idle();
    rst = 1'b1;
    #8;
    check("rst_rd_w", bus.rd_w, 0);
    check("rst_result_w", bus.result_w, 0);
    check("rst_reg_write", bus.reg_write_w, 0);
    check("rst_fpu_write", bus.fpu_reg_write_w, 0);
    check("rst_pipe_hold", bus.pipe_hold, 0);
    check("rst_lu_ready", bus.lu_ready, 0);
    check("rst_stall", bus.stall_d, 0);
    #4 rst = 1'b0;
    tick();

    // Both units from idle: unit 0 then unit 1
    lu_req(0, 5'd7, 32'hA0A0_0001, 1'b0);
    lu_req(1, 5'd8, 32'hB0B0_0002, 1'b1);
    #1 check("rr_first", bus.lu_ready, 2'b01);
    expect_write(5'd7, 32'hA0A0_0001, 1'b0);
    tick();
    bus.lu_valid[0] = 1'b0;
    #1 check("rr_second", bus.lu_ready, 2'b10);
    expect_write(5'd8, 32'hB0B0_0002, 1'b1);
    tick();
    idle();

    // Plain pipeline write
    pipe_req(5'd5, 32'hDEAD_BEEF, 1'b0);
    expect_write(5'd5, 32'hDEAD_BEEF, 1'b0);
    tick();
    idle();
    #1;
    check("pipe_rd_w", bus.rd_w, 5);
    check("pipe_result_w", bus.result_w, 32'hDEAD_BEEF);
    check("pipe_reg_write", bus.reg_write_w, 1);
    check("pipe_fpu_write", bus.fpu_reg_write_w, 0);

    // Pipeline write to x0 is consumed but not enabled, then held
    pipe_req(5'd0, 32'h0000_1234, 1'b0);
    tick();
    idle();
    #1;
    check("x0_reg_write", bus.reg_write_w, 0);
    check("x0_rd_w", bus.rd_w, 0);
    check("x0_result_w", bus.result_w, 32'h0000_1234);
    tick();
    check("hold_result_w", bus.result_w, 32'h0000_1234);
    check("hold_fpu_write", bus.fpu_reg_write_w, 0);

    // Issue to integer x0 never becomes pending
    issue(5'd0, 1'b0);
    tick();
    idle();
    bus.dec_use = 4'b1111; bus.dec_fpu = 4'b0000;
    #1 check("x0_no_stall", bus.stall_d, 0);
    idle();

    // Issue f3, decode stalls on f3 but not x3, fdiv returns f3
    issue(5'd3, 1'b1);
    tick();
    idle();
    bus.dec_rs1 = 5'd3; bus.dec_use = 4'b0001; bus.dec_fpu = 4'b0001;
    #1 check("f3_stall", bus.stall_d, 1);
    bus.dec_fpu = 4'b0000;
    #1 check("x3_no_stall", bus.stall_d, 0);
    bus.dec_rs3 = 5'd3; bus.dec_use = 4'b0100; bus.dec_fpu = 4'b0100;
    #1 check("f3_rs3_stall", bus.stall_d, 1);
    bus.dec_use = 4'b0001; bus.dec_fpu = 4'b0001;
    lu_req(0, 5'd3, 32'h4040_0000, 1'b1);
    #1 check("fdiv_ready", bus.lu_ready, 2'b01);
    expect_write(5'd3, 32'h4040_0000, 1'b1);
    tick();
    bus.lu_valid = 2'b00;
    #1;
    check("f3_cleared", bus.stall_d, 0);
    check("fdiv_fpu_write", bus.fpu_reg_write_w, 1);
    check("fdiv_rd_w", bus.rd_w, 3);
    idle();

    // Same-cycle set and clear of f4: set wins
    issue(5'd4, 1'b1);
    tick();
    idle();
    lu_req(0, 5'd4, 32'h0000_4444, 1'b1);
    issue(5'd4, 1'b1);
    expect_write(5'd4, 32'h0000_4444, 1'b1);
    tick();
    idle();
    bus.dec_rs2 = 5'd4; bus.dec_use = 4'b0010; bus.dec_fpu = 4'b0010;
    #1 check("set_wins", bus.stall_d, 1);
    lu_req(0, 5'd4, 32'h0000_4445, 1'b1);
    expect_write(5'd4, 32'h0000_4445, 1'b1);
    tick();
    bus.lu_valid = 2'b00;
    #1 check("f4_cleared", bus.stall_d, 0);
    idle();

    // Starvation: pipeline streams while fsqrt waits
    for (int i = 0; i < 4; i++) begin
      pipe_req(5'(10 + i), 32'h0000_1000 + 32'(i), 1'b0);
      lu_req(1, 5'd9, 32'hC0C0_0009, 1'b0);
      #1;
      check("starve_no_hold", bus.pipe_hold, 0);
      check("starve_denied", bus.lu_ready, 2'b00);
      expect_write(5'(10 + i), 32'h0000_1000 + 32'(i), 1'b0);
      tick();
    end
    pipe_req(5'd20, 32'h0000_2000, 1'b0);
    #1;
    check("starve_hold", bus.pipe_hold, 1);
    check("starve_fsqrt_ready", bus.lu_ready, 2'b10);
    expect_write(5'd9, 32'hC0C0_0009, 1'b0);
    tick();
    bus.lu_valid = 2'b00;
    pipe_req(5'd21, 32'h0000_2100, 1'b0);
    #1;
    check("hold_one_cycle", bus.pipe_hold, 0);
    check("post_hold_ready", bus.lu_ready, 2'b00);
    expect_write(5'd21, 32'h0000_2100, 1'b0);
    tick();
    idle();
    tick();

    // Reset in the middle of an fdiv transfer
    issue(5'd5, 1'b1);
    tick();
    idle();
    bus.dec_rs1 = 5'd5; bus.dec_use = 4'b0001; bus.dec_fpu = 4'b0001;
    #1 check("f5_stall", bus.stall_d, 1);
    lu_req(0, 5'd5, 32'h0000_0055, 1'b1);
    #1 check("f5_ready", bus.lu_ready, 2'b01);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_lu_ready", bus.lu_ready, 0);
    check("mid_rst_rd_w", bus.rd_w, 0);
    check("mid_rst_result_w", bus.result_w, 0);
    check("mid_rst_reg_write", bus.reg_write_w, 0);
    check("mid_rst_fpu_write", bus.fpu_reg_write_w, 0);
    check("mid_rst_pipe_hold", bus.pipe_hold, 0);
    check("mid_rst_stall", bus.stall_d, 0);
    tick();
    bus.lu_valid = 2'b00;
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_reg_write", bus.reg_write_w, 0);
    check("post_rst_fpu_write", bus.fpu_reg_write_w, 0);
    check("post_rst_stall", bus.stall_d, 0);

    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_port_scheduler.md
WB_PORT_SCHEDULER -- requirements
Module: wb_port_scheduler

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive denied cycles of a waiting long-latency unit before the pipeline writeback is held.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports pipe_wr_valid/pipe_fpu  in  1/1  in-order pipeline writeback request; target is the FPU file when pipe_fpu=1.
REQ-005 SHALL have ports pipe_rd/pipe_result  in  5/32  pipeline destination and data.
REQ-006 SHALL have ports lu_valid/lu_ready  in/out  2/2  per long-latency unit (0=fdiv, 1=fsqrt) result handshake.
REQ-007 SHALL have ports lu_rd/lu_fpu/lu_result  in  2x5/2x1/2x32  per-unit destination, file select, data.
REQ-008 SHALL have ports issue_valid/issue_rd/issue_fpu  in  1/5/1  long-latency op dispatched this cycle; marks destination pending.
REQ-009 SHALL have ports dec_rs1/dec_rs2/dec_rs3/dec_rd  in  5 each  decode-stage operand and destination indices.
REQ-010 SHALL have ports dec_use/dec_fpu  in  4/4  per-field use enable and file select, bit order {rd,rs3,rs2,rs1}.
REQ-011 SHALL have port stall_d  out  1  decode must stall (hazard on a pending register).
REQ-012 SHALL have port pipe_hold  out  1  registered; upstream must not present pipe_wr_valid in the following cycle.
REQ-013 SHALL have ports rd_w/result_w/reg_write_w/fpu_reg_write_w  out  5/32/1/1  registered shared register-file write port.

Function
REQ-014 SHALL grant the single write port to at most one requester per cycle; grant is combinational, write port output registered (1-cycle latency grant -> rd_w/result_w).
REQ-015 SHALL grant the pipeline whenever pipe_wr_valid=1 and pipe_hold=0; pipeline is never back-pressured otherwise.
REQ-016 SHALL, when the pipeline is not granted, grant among asserted lu_valid by round-robin; pointer starts at unit 0 and moves to the other unit after each long-unit grant.
REQ-017 SHALL assert lu_ready[i] only in the cycle unit i is granted; a transfer is lu_valid[i] & lu_ready[i]; lu_* inputs held stable until transfer.
REQ-018 SHALL set reg_write_w=1 on a granted write with file select 0 and rd!=0; fpu_reg_write_w=1 with file select 1 (f0 writable); both 0 in idle cycles and for integer x0 (request still consumed).
REQ-019 SHALL hold rd_w/result_w at last value when no write is granted.
REQ-020 SHALL keep 64-bit pending scoreboard (int 0-31, fp 32-63); issue_valid sets bit {issue_fpu,issue_rd} except integer x0; long-unit transfer clears bit {lu_fpu,lu_rd}, same edge as output register load.
REQ-021 SHALL give set priority over clear when both target the same bit in one cycle.
REQ-022 SHALL drive stall_d combinationally = OR over fields f with dec_use[f]=1 of pending[{dec_fpu[f],index_f}]; integer x0 never stalls.
REQ-023 SHALL keep a starvation counter: increment (saturating at STARVE_LIMIT) each cycle any lu_valid=1 with no long-unit grant; clear on long-unit grant or when no lu_valid.
REQ-024 SHALL register pipe_hold=1 for exactly one cycle when counter reaches STARVE_LIMIT; in that cycle a waiting long unit is granted, pipe_wr_valid is ignored (protocol violation, not written).
REQ-025 SHALL, with pipe_hold=1 and no lu_valid, grant nothing and clear the counter.

Reset
REQ-026 SHALL on rst=1 immediately clear pending, counter, round-robin pointer (unit 0), pipe_hold, lu_ready, rd_w, result_w, reg_write_w, fpu_reg_write_w.
REQ-027 SHALL, on reset mid-transfer, drop the in-flight grant; no write appears after rst deasserts.

Verification
REQ-028 SHALL pass: pipe_wr_valid, pipe_rd=5, pipe_result=0xDEADBEEF, pipe_fpu=0 -> next cycle rd_w=5, result_w=0xDEADBEEF, reg_write_w=1, fpu_reg_write_w=0.
REQ-029 SHALL pass: issue f3 (fpu), decode rs1=f3 used -> stall_d=1; fdiv returns f3 -> stall_d=0 next cycle, fpu_reg_write_w=1, rd_w=3.
REQ-030 SHALL pass: both lu_valid from idle, no pipeline -> unit 0 granted cycle N, unit 1 cycle N+1.
REQ-031 SHALL pass: continuous pipe_wr_valid, lu_valid[1]=1, STARVE_LIMIT=4 -> pipe_hold=1 after 4 denied cycles, fsqrt granted that cycle, counter 0.
REQ-032 SHALL pass: pipeline write to x0 -> reg_write_w=0; issue x0 -> no pending bit, stall_d=0.
REQ-033 SHALL pass: rst asserted during lu transfer -> all outputs 0 same cycle, pending all 0.
